// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin, message-locked scheduler sharing one uart_tx
//               serializer between NREQ valid/ready byte-stream requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter  int NREQ = 4,
  parameter  int DW   = 8,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [NREQ-1:0]    req_valid_i,
  input  logic [NREQ*DW-1:0] req_data_i,
  input  logic [NREQ-1:0]    req_last_i,
  output logic [NREQ-1:0]    req_ready_o,
  output logic               utx_start_o,
  output logic [DW-1:0]      utx_data_o,
  input  logic               utx_busy_i,
  output logic [IDW-1:0]     grant_id_o,
  output logic               active_o
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD      = 2'd1,
    S_START     = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [IDW-1:0] r_owner;
  logic [IDW-1:0] r_last_owner;
  logic [DW-1:0]  r_data;
  logic           r_last_q;
  logic           r_lock;
  logic [IDW-1:0] w_pick;
  logic           w_grant;
  logic           w_capture;
  logic           w_done;
  logic [DW-1:0]  w_bytes [NREQ];

  for (genvar k = 0; k < NREQ; k++) begin : g_unpack
    assign w_bytes[k] = req_data_i[k*DW +: DW];
  end

  // Descending scan so the requester closest after last_owner wins.
  always_comb begin
    logic [IDW-1:0] v_idx;
    v_idx  = '0;
    w_pick = '0;
    for (int i = NREQ; i >= 1; i--) begin
      v_idx = IDW'((int'(r_last_owner) + i) % NREQ);
      if (req_valid_i[v_idx]) w_pick = v_idx;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_capture   = 1'b0;
    w_done      = 1'b0;
    utx_start_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!utx_busy_i && (|req_valid_i)) begin
          w_grant     = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (req_valid_i[r_owner]) begin
          w_capture   = 1'b1;
          w_state_nxt = S_START;
        end else if (!r_lock) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        utx_start_o = 1'b1;
        if (utx_busy_i) w_state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!utx_busy_i) begin
          w_done      = 1'b1;
          w_state_nxt = r_last_q ? S_IDLE : S_LOAD;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= S_IDLE;
      r_owner      <= '0;
      r_last_owner <= IDW'(NREQ - 1);
      r_data       <= '0;
      r_last_q     <= 1'b0;
      r_lock       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) r_owner <= w_pick;
      if (w_capture) begin
        r_data   <= w_bytes[r_owner];
        r_last_q <= req_last_i[r_owner];
      end
      // Pointer only moves on a completed message, keeping abandoned grants free.
      if (w_done) begin
        if (r_last_q) begin
          r_last_owner <= r_owner;
          r_lock       <= 1'b0;
        end else begin
          r_lock <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (r_state == S_LOAD) req_ready_o[r_owner] = 1'b1;
  end

  assign utx_data_o = r_data;
  assign grant_id_o = r_owner;
  assign active_o   = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Scoreboard bench for uart_tx_arbiter with a busy-only uart_tx model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int NREQ   = 4;
  localparam int DW     = 8;
  localparam int BUSY_N = 20;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              utx_start;
  logic [DW-1:0]     utx_data;
  logic              utx_busy;
  logic [1:0]        grant_id;
  logic              active;

  exp_t       exp_q [$];
  logic [8:0] src_q [NREQ][$];
  logic [NREQ-1:0] fire;
  logic       ovr_en;
  logic [1:0] ovr_id;
  int         busy_cnt;
  int         n_vec;
  int         n_err;

  uart_tx_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_last_i  (req_last),
    .req_ready_o (req_ready),
    .utx_start_o (utx_start),
    .utx_data_o  (utx_data),
    .utx_busy_i  (utx_busy),
    .grant_id_o  (grant_id),
    .active_o    (active)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // uart_tx stand-in: samples start, raises busy next cycle for BUSY_N cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      utx_busy <= 1'b0;
      busy_cnt <= 0;
    end else if (utx_busy) begin
      if (busy_cnt == BUSY_N - 1) utx_busy <= 1'b0;
      busy_cnt <= busy_cnt + 1;
    end else if (utx_start) begin
      utx_busy <= 1'b1;
      busy_cnt <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Requester driver: presents queue heads, retires bytes after a handshake edge.
  initial begin
    logic [NREQ-1:0]    v;
    logic [NREQ*DW-1:0] d;
    logic [NREQ-1:0]    l;
    forever begin
      @(negedge clk);
      for (int k = 0; k < NREQ; k++)
        if (fire[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
      v = '0; d = '0; l = '0;
      for (int k = 0; k < NREQ; k++) begin
        if (src_q[k].size() > 0) begin
          v[k]        = 1'b1;
          d[k*DW +: DW] = src_q[k][0][7:0];
          l[k]        = src_q[k][0][8];
        end
      end
      if (ovr_en) begin
        v[ovr_id] = 1'b1;
        d[ovr_id*DW +: DW] = 8'hEE;
        l[ovr_id] = 1'b1;
        ovr_en = 1'b0;
      end
      req_valid = v;
      req_data  = d;
      req_last  = l;
      fire = rst_n ? (v & req_ready) : '0;
    end
  end

  // Monitor: each byte accepted by the serializer is checked against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      chk("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
      if (rst_n && utx_start && !utx_busy) begin
        if (exp_q.size() == 0) begin
          chk("spurious_start", 32'(utx_start), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("grant_id", 32'(grant_id), 32'(e.id));
          chk("tx_data", 32'(utx_data), 32'(e.data));
        end
      end
    end
  end

  task automatic push_msg(input int k, input logic [7:0] data, input logic last, input logic expect_it);
    src_q[k].push_back({last, data});
    if (expect_it) exp_q.push_back('{id: 2'(k), data: data});
  endtask

  task automatic wait_idle(input string tag);
    int n;
    int pend;
    n = 0;
    pend = 1;
    while ((pend != 0 || exp_q.size() != 0 || active) && n < 3000) begin
      @(negedge clk);
      #2;
      n++;
      pend = 0;
      for (int k = 0; k < NREQ; k++) pend += src_q[k].size();
    end
    chk({tag, "_timeout"}, 32'(n >= 3000), 32'd0);
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_start"}, 32'(utx_start), 32'd0);
    chk({tag, "_data"}, 32'(utx_data), 32'd0);
    chk({tag, "_grant"}, 32'(grant_id), 32'd0);
    chk({tag, "_active"}, 32'(active), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check_reset_outputs("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    n_vec = 0; n_err = 0;
    rst_n = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0;
    fire = '0; ovr_en = 1'b0; ovr_id = '0;
    do_reset();

    // Single byte: latency IDLE->LOAD->START.
    @(posedge clk);
    push_msg(0, 8'hA5, 1'b1, 1'b1);
    @(negedge clk); #1;
    chk("t1_ready_pre", 32'(req_ready), 32'd0);
    @(negedge clk); #1;
    chk("t1_ready", 32'(req_ready), 32'b0001);
    chk("t1_active", 32'(active), 32'd1);
    @(negedge clk); #1;
    chk("t1_start", 32'(utx_start), 32'd1);
    chk("t1_data", 32'(utx_data), 32'hA5);
    wait_idle("t1");

    // Message lock: req2 waits for req1's whole message.
    @(posedge clk);
    push_msg(1, 8'h11, 1'b0, 1'b1);
    push_msg(1, 8'h22, 1'b0, 1'b1);
    push_msg(1, 8'h33, 1'b1, 1'b1);
    push_msg(2, 8'h44, 1'b1, 1'b1);
    wait_idle("t2");

    // Round robin from reset.
    do_reset();
    @(posedge clk);
    for (int j = 0; j < 2; j++)
      for (int k = 0; k < NREQ; k++)
        push_msg(k, 8'(8'h10 * (k + 1) + j), 1'b1, 1'b1);
    wait_idle("t3");

    // Owner stall mid-message; req0 must wait.
    @(posedge clk);
    exp_q.push_back('{id: 2'd3, data: 8'h01});
    exp_q.push_back('{id: 2'd3, data: 8'h02});
    exp_q.push_back('{id: 2'd0, data: 8'h55});
    src_q[3].push_back({1'b0, 8'h01});
    n = 0;
    while (!(exp_q.size() == 2 && req_ready == 4'b1000 && !utx_busy) && n < 500) begin
      @(negedge clk); #2; n++;
    end
    chk("t4_reach_load", 32'(exp_q.size()), 32'd2);
    @(posedge clk);
    src_q[0].push_back({1'b1, 8'h55});
    repeat (50) @(negedge clk);
    #1;
    chk("t4_stall_ready", 32'(req_ready), 32'b1000);
    chk("t4_stall_grant", 32'(grant_id), 32'd3);
    chk("t4_no_start", 32'(exp_q.size()), 32'd2);
    @(posedge clk);
    src_q[3].push_back({1'b1, 8'h02});
    wait_idle("t4");

    // Move last_owner to 1, then abandon a grant to req2.
    @(posedge clk);
    push_msg(1, 8'h5A, 1'b1, 1'b1);
    wait_idle("t5a");
    @(posedge clk);
    ovr_id = 2'd2;
    ovr_en = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    chk("t5_ready_abandon", 32'(req_ready), 32'b0100);
    @(negedge clk); #1;
    chk("t5_back_idle", 32'(active), 32'd0);
    chk("t5_no_start", 32'(utx_start), 32'd0);
    @(posedge clk);
    push_msg(2, 8'hB2, 1'b1, 1'b1);
    push_msg(1, 8'hB1, 1'b1, 1'b1);
    wait_idle("t5b");

    // Asynchronous reset during WAIT_DONE.
    @(posedge clk);
    push_msg(0, 8'h3C, 1'b1, 1'b1);
    n = 0;
    while (!utx_busy && n < 100) begin
      @(negedge clk); n++;
    end
    chk("t6_busy_seen", 32'(utx_busy), 32'd1);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    push_msg(2, 8'h77, 1'b0, 1'b0);
    src_q[2][0] = {1'b1, 8'h77};
    push_msg(0, 8'h66, 1'b1, 1'b1);
    exp_q.push_back('{id: 2'd2, data: 8'h77});
    wait_idle("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
